// File: rtl/ltch_array_wr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Package: ltch_wr_pkg
// Purpose: Shared types for the latch-array write controller.
//          ST_W     - width of the controller state encoding
//          ltch_wr_state_e - IDLE / SETUP / EN / HOLD write sequence states
// ----------------------------------------------------------------------------
package ltch_wr_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EN    = 2'd2,
    HOLD  = 2'd3
  } ltch_wr_state_e;

endpackage

// File: rtl/ltch_array_wr_ctrl_if.sv
// ----------------------------------------------------------------------------
// Interface: ltch_array_wr_ctrl_if
// Purpose: Write-request channel between the requester (EXU commit) and the
//          latch-array write controller.
//   wr_vld  requester -> ctrl   request valid
//   wr_addr requester -> ctrl   target entry index
//   wr_data requester -> ctrl   write data
//   wr_rdy  ctrl -> requester   controller can accept this cycle
//   wr_err  ctrl -> requester   1-cycle pulse: accepted address was out of range
// ----------------------------------------------------------------------------
interface ltch_array_wr_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          wr_vld;
  logic          wr_rdy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  modport master (
    output wr_vld,
    output wr_addr,
    output wr_data,
    input  wr_rdy,
    input  wr_err
  );

  modport slave (
    input  wr_vld,
    input  wr_addr,
    input  wr_data,
    output wr_rdy,
    output wr_err
  );

endinterface

// File: rtl/ltch_array_wr_ctrl_chk.sv
// ----------------------------------------------------------------------------
// Module: ltch_array_wr_ctrl_chk
// Purpose: Simulation-only property checker for ltch_array_wr_ctrl outputs.
//          Enables are one-hot-or-zero and never X; ready never X; the shared
//          data bus is stable across the EN cycle and the HOLD cycle.
// Ports:
//   clk, rst   controller clock and reset
//   ltch_lden  observed latch enables
//   ltch_dnxt  observed latch data bus
//   wr_rdy     observed request ready
// ----------------------------------------------------------------------------
module ltch_array_wr_ctrl_chk #(
  parameter int DW  = 32,
  parameter int NUM = 32
) (
  input logic           clk,
  input logic           rst,
  input logic [NUM-1:0] ltch_lden,
  input logic [DW-1:0]  ltch_dnxt,
  input logic           wr_rdy
);

  a_lden_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(ltch_lden));

  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(ltch_lden) && !$isunknown(wr_rdy));

  // Data entering EN must equal what was presented in SETUP.
  a_data_stable_en: assert property (@(posedge clk) disable iff (rst)
    (|ltch_lden) |-> $stable(ltch_dnxt));

  // The cycle after EN is HOLD; data must not move there either.
  a_data_stable_hold: assert property (@(posedge clk) disable iff (rst)
    $past(|ltch_lden) |-> $stable(ltch_dnxt));

endmodule

// File: rtl/ltch_array_wr_ctrl.sv
// ----------------------------------------------------------------------------
// Module: ltch_array_wr_ctrl
// Purpose: Write-side controller for an external latch-based storage array.
//          A request is staged in flops, then the target latch enable is
//          driven with a SETUP / EN / HOLD sequence so the shared data bus is
//          stable before, during and after the single-cycle enable pulse.
//          The in-flight write is offered as a read bypass.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   wr_if      write request channel (slave side)
//   ltch_lden  per-entry latch enables, one-hot or zero
//   ltch_dnxt  data to the latch array, shared by all entries
//   rd_addr    read address being looked up in the array
//   byp_hit    in-flight write targets rd_addr
//   byp_data   staged write data for bypass
//   busy       write sequence in progress (state != IDLE)
// ----------------------------------------------------------------------------
module ltch_array_wr_ctrl
  import ltch_wr_pkg::*;
#(
  parameter  int DW  = 32,
  parameter  int NUM = 32,
  localparam int AW  = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  ltch_array_wr_ctrl_if.slave  wr_if,
  output logic [NUM-1:0]       ltch_lden,
  output logic [DW-1:0]        ltch_dnxt,
  input  logic [AW-1:0]        rd_addr,
  output logic                 byp_hit,
  output logic [DW-1:0]        byp_data,
  output logic                 busy
);

  // NUM widened by one bit so the range check also works when NUM is 2**AW.
  localparam logic [AW:0] NUM_W = (AW+1)'(NUM);

  ltch_wr_state_e state_q,    state_d;
  logic [AW-1:0]  stg_addr_q, stg_addr_d;
  logic [DW-1:0]  stg_data_q, stg_data_d;
  logic           err_q,      err_d;

  logic           wr_rdy_s;
  logic           accept_s;
  logic           addr_ok_s;
  logic [NUM-1:0] lden_s;

  // Ready only in IDLE/HOLD, and forced low while reset is held.
  always_comb begin
    if (rst) begin
      wr_rdy_s = 1'b0;
    end else begin
      wr_rdy_s = (state_q == IDLE) || (state_q == HOLD);
    end
  end

  assign accept_s     = wr_if.wr_vld & wr_rdy_s;
  assign addr_ok_s    = ({1'b0, wr_if.wr_addr} < NUM_W);
  assign wr_if.wr_rdy = wr_rdy_s;
  assign wr_if.wr_err = err_q;

  // Next-state, staging and error-pulse computation.
  always_comb begin
    state_d    = state_q;
    stg_addr_d = stg_addr_q;
    stg_data_d = stg_data_q;
    err_d      = 1'b0;

    if (accept_s) begin
      stg_addr_d = wr_if.wr_addr;
      stg_data_d = wr_if.wr_data;
      err_d      = ~addr_ok_s;
    end else begin
      stg_addr_d = stg_addr_q;
      stg_data_d = stg_data_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s && addr_ok_s) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: state_d = EN;
      EN:    state_d = HOLD;
      HOLD: begin
        // A bad-address accept in HOLD ends the sequence just like no request.
        if (accept_s && addr_ok_s) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All controller flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
      err_q      <= err_d;
    end
  end

  // Enable decode from registered state and address only, so no request-side
  // input can glitch an enable. Out-of-range addresses never reach EN.
  always_comb begin
    lden_s = '0;
    for (int i = 0; i < NUM; i++) begin
      if ((state_q == EN) && (stg_addr_q == AW'(i))) begin
        lden_s[i] = 1'b1;
      end else begin
        lden_s[i] = 1'b0;
      end
    end
  end

  // Reset kills the enables immediately, abandoning a write caught mid-EN.
  always_comb begin
    if (rst) begin
      ltch_lden = '0;
    end else begin
      ltch_lden = lden_s;
    end
  end

  assign ltch_dnxt = stg_data_q;
  assign byp_data  = stg_data_q;
  assign busy      = (state_q != IDLE);
  assign byp_hit   = busy && (rd_addr == stg_addr_q);

endmodule
